// File: rtl/scan_pkg.sv
// Shared types and constants for the truth-table scanner.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int N_VEC = 16;
    localparam int IDX_W = 4;

    // A vector with no settle time goes straight to sampling.
    function automatic state_t entry_state(input int settle_cycles);
        return (settle_cycles == 0) ? CAPTURE : SETTLE;
    endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Loadable down-counter timing how long each stimulus vector is held before sampling.
module settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic tick,
    output logic expired
);
    import scan_pkg::*;

    localparam logic [3:0] LOAD_VAL = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    logic [3:0] cnt_r;

    // Reload on vector entry, otherwise count down while settling.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= 4'd0;
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (tick && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == 4'd0);

endmodule

// File: rtl/truth_table_scanner.sv
// Drives all 16 input vectors into `main`, samples O and builds its truth table.
// Optional popcount output `ones` is built when SCAN_ONES_EN is defined.
module truth_table_scanner
    import scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        I0,
    output logic        I1,
    output logic        I2,
    output logic        I3,
    input  logic        O,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table
`ifdef SCAN_ONES_EN
    ,
    output logic [4:0]  ones
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_VEC - 1);
    localparam state_t           VEC_ENTRY  = entry_state(SETTLE_CYCLES);

    state_t            state_r;
    logic [IDX_W-1:0]  idx_r;
    logic              load_s;
    logic              tick_s;
    logic              expired_s;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rstn    (rstn),
        .load    (load_s),
        .tick    (tick_s),
        .expired (expired_s)
    );

    // Timer reloads whenever a new vector is about to be presented.
    always_comb begin
        load_s = 1'b0;
        case (state_r)
            IDLE, DONE: load_s = start;
            CAPTURE:    load_s = (idx_r != LAST_IDX);
            default:    load_s = 1'b0;
        endcase
    end

    assign tick_s = (state_r == SETTLE);

    // Scan sequencer with registered stimulus, status and table.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            idx_r       <= {IDX_W{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= 16'h0000;
`ifdef SCAN_ONES_EN
            ones        <= 5'd0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        idx_r       <= {IDX_W{1'b0}};
                        truth_table <= 16'h0000;
`ifdef SCAN_ONES_EN
                        ones        <= 5'd0;
`endif
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        state_r     <= VEC_ENTRY;
                    end
                end
                SETTLE: begin
                    if (expired_s) begin
                        state_r <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    truth_table[idx_r] <= O;
`ifdef SCAN_ONES_EN
                    ones <= ones + {4'd0, O};
`endif
                    if (idx_r == LAST_IDX) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        state_r <= VEC_ENTRY;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign {I0, I1, I2, I3} = idx_r;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench: three scanner instances (settle 1, 0, 3) each driving a selectable `main` model.
module tb_truth_table_scanner;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start1 = 1'b0, start0 = 1'b0, start3 = 1'b0;
    int   mode1 = 2, mode0 = 3, mode3 = 1;
    logic a0_1, a1_1, a2_1, a3_1, o_1, busy1, done1;
    logic a0_0, a1_0, a2_0, a3_0, o_0, busy0, done0;
    logic a0_3, a1_3, a2_3, a3_3, o_3, busy3, done3;
    logic [15:0] tt1, tt0, tt3;
`ifdef SCAN_ONES_EN
    logic [4:0] ones1, ones0, ones3;
`endif

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  ones;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];
    logic [3:0] idx_q[$];

    always #5 clk = ~clk;

    // 0: constant 0, 1: constant 1, 2: XOR, 3: AND
    function automatic logic model(input int mode, input logic [3:0] v);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ^v;
            3:       return &v;
            default: return 1'b0;
        endcase
    endfunction

    assign o_1 = model(mode1, {a0_1, a1_1, a2_1, a3_1});
    assign o_0 = model(mode0, {a0_0, a1_0, a2_0, a3_0});
    assign o_3 = model(mode3, {a0_3, a1_3, a2_3, a3_3});

    truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rstn(rstn), .start(start1),
        .I0(a0_1), .I1(a1_1), .I2(a2_1), .I3(a3_1), .O(o_1),
        .busy(busy1), .done(done1), .truth_table(tt1)
`ifdef SCAN_ONES_EN
        , .ones(ones1)
`endif
    );

    truth_table_scanner #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rstn(rstn), .start(start0),
        .I0(a0_0), .I1(a1_0), .I2(a2_0), .I3(a3_0), .O(o_0),
        .busy(busy0), .done(done0), .truth_table(tt0)
`ifdef SCAN_ONES_EN
        , .ones(ones0)
`endif
    );

    truth_table_scanner #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rstn(rstn), .start(start3),
        .I0(a0_3), .I1(a1_3), .I2(a2_3), .I3(a3_3), .O(o_3),
        .busy(busy3), .done(done3), .truth_table(tt3)
`ifdef SCAN_ONES_EN
        , .ones(ones3)
`endif
    );

    // Pulse start for one instance; returns just after the sampling edge (edge 0).
    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0:       start0 = 1'b1;
            1:       start1 = 1'b1;
            default: start3 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    // Counts cycles after edge 0 until done is seen, bounded.
    task automatic wait_done(input int which, output int cycles);
        cycles = 0;
        while (cycles < 300) begin
            if ((which == 0) ? done0 : (which == 1) ? done1 : done3) break;
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        #3;
        total++; if ({a0_1, a1_1, a2_1, a3_1} !== 4'd0) begin bad++; $display("FAIL reset_idx got=%h want=0", {a0_1, a1_1, a2_1, a3_1}); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy1); end
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done1); end
        total++; if (tt1 !== 16'h0000) begin bad++; $display("FAIL reset_table got=%h want=0000", tt1); end
`ifdef SCAN_ONES_EN
        total++; if (ones1 !== 5'd0) begin bad++; $display("FAIL reset_ones got=%0d want=0", ones1); end
`endif
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_xor();
        exp_t e;
        int   cyc;
        mode1 = 2;
        exp_q.push_back('{tbl: 16'h6996, ones: 5'd8, cyc: 32});
        pulse(1);
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL xor_busy got=%b want=1", busy1); end
        wait_done(1, cyc);
        e = exp_q.pop_front();
        total++; if (cyc !== e.cyc) begin bad++; $display("FAIL xor_latency got=%0d want=%0d", cyc, e.cyc); end
        total++; if (tt1 !== e.tbl) begin bad++; $display("FAIL xor_table got=%h want=%h", tt1, e.tbl); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL xor_busy_done got=%b want=0", busy1); end
`ifdef SCAN_ONES_EN
        total++; if (ones1 !== e.ones) begin bad++; $display("FAIL xor_ones got=%0d want=%0d", ones1, e.ones); end
`endif
        repeat (3) @(posedge clk);
        #1;
        total++; if (tt1 !== e.tbl || done1 !== 1'b1) begin bad++; $display("FAIL xor_hold got=%h/%b want=%h/1", tt1, done1, e.tbl); end
    endtask

    task automatic test_and();
        exp_t       e;
        logic [3:0] ei;
        int         cyc;
        mode0 = 3;
        exp_q.push_back('{tbl: 16'h8000, ones: 5'd1, cyc: 16});
        for (int k = 0; k < 16; k++) idx_q.push_back(4'(k));
        pulse(0);
        cyc = 0;
        while (!done0 && cyc < 300) begin
            if (idx_q.size() > 0) begin
                ei = idx_q.pop_front();
                total++; if ({a0_0, a1_0, a2_0, a3_0} !== ei) begin bad++; $display("FAIL and_step got=%h want=%h", {a0_0, a1_0, a2_0, a3_0}, ei); end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        e = exp_q.pop_front();
        total++; if (cyc !== e.cyc) begin bad++; $display("FAIL and_latency got=%0d want=%0d", cyc, e.cyc); end
        total++; if (tt0 !== e.tbl) begin bad++; $display("FAIL and_table got=%h want=%h", tt0, e.tbl); end
`ifdef SCAN_ONES_EN
        total++; if (ones0 !== e.ones) begin bad++; $display("FAIL and_ones got=%0d want=%0d", ones0, e.ones); end
`endif
    endtask

    task automatic test_const1_midstart();
        exp_t e;
        int   cyc;
        mode3 = 1;
        exp_q.push_back('{tbl: 16'hFFFF, ones: 5'd16, cyc: 64});
        pulse(3);
        cyc = 0;
        while (!done3 && cyc < 300) begin
            start3 = (cyc == 20);
            @(posedge clk);
            #1;
            cyc++;
        end
        start3 = 1'b0;
        e = exp_q.pop_front();
        total++; if (cyc !== e.cyc) begin bad++; $display("FAIL const1_latency got=%0d want=%0d", cyc, e.cyc); end
        total++; if (tt3 !== e.tbl) begin bad++; $display("FAIL const1_table got=%h want=%h", tt3, e.tbl); end
`ifdef SCAN_ONES_EN
        total++; if (ones3 !== e.ones) begin bad++; $display("FAIL const1_ones got=%0d want=%0d", ones3, e.ones); end
`endif
    endtask

    task automatic test_restart_in_done();
        exp_t e;
        int   cyc;
        mode1 = 0;
        exp_q.push_back('{tbl: 16'h0000, ones: 5'd0, cyc: 32});
        pulse(1);
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL restart_done_drop got=%b want=0", done1); end
        total++; if (tt1 !== 16'h0000) begin bad++; $display("FAIL restart_clear got=%h want=0000", tt1); end
        wait_done(1, cyc);
        e = exp_q.pop_front();
        total++; if (cyc !== e.cyc) begin bad++; $display("FAIL restart_latency got=%0d want=%0d", cyc, e.cyc); end
        total++; if (tt1 !== e.tbl) begin bad++; $display("FAIL restart_table got=%h want=%h", tt1, e.tbl); end
`ifdef SCAN_ONES_EN
        total++; if (ones1 !== e.ones) begin bad++; $display("FAIL restart_ones got=%0d want=%0d", ones1, e.ones); end
`endif
    endtask

    task automatic test_reset_midscan();
        exp_t e;
        int   cyc;
        mode1 = 2;
        pulse(1);
        cyc = 0;
        while ({a0_1, a1_1, a2_1, a3_1} != 4'd7 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        total++; if ({a0_1, a1_1, a2_1, a3_1} !== 4'd7) begin bad++; $display("FAIL midrst_reach got=%h want=7", {a0_1, a1_1, a2_1, a3_1}); end
        #2;
        rstn = 1'b0;
        #1;
        total++; if ({a0_1, a1_1, a2_1, a3_1} !== 4'd0) begin bad++; $display("FAIL midrst_idx got=%h want=0", {a0_1, a1_1, a2_1, a3_1}); end
        total++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin bad++; $display("FAIL midrst_status got=%b%b want=00", busy1, done1); end
        total++; if (tt1 !== 16'h0000) begin bad++; $display("FAIL midrst_table got=%h want=0000", tt1); end
`ifdef SCAN_ONES_EN
        total++; if (ones1 !== 5'd0) begin bad++; $display("FAIL midrst_ones got=%0d want=0", ones1); end
`endif
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        exp_q.push_back('{tbl: 16'h6996, ones: 5'd8, cyc: 32});
        pulse(1);
        wait_done(1, cyc);
        e = exp_q.pop_front();
        total++; if (cyc !== e.cyc) begin bad++; $display("FAIL midrst_latency got=%0d want=%0d", cyc, e.cyc); end
        total++; if (tt1 !== e.tbl) begin bad++; $display("FAIL midrst_table_rescan got=%h want=%h", tt1, e.tbl); end
`ifdef SCAN_ONES_EN
        total++; if (ones1 !== e.ones) begin bad++; $display("FAIL midrst_ones_rescan got=%0d want=%0d", ones1, e.ones); end
`endif
    endtask

    initial begin
        test_reset();
        test_xor();
        test_and();
        test_const1_midstart();
        test_restart_in_done();
        test_reset_midscan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
